// File: rtl/iob_eth_tx_sched_if.sv
// Handshake bundle between the TX frame scheduler, its requesters and the nibble transmitter.
interface iob_eth_tx_sched_if #(
  parameter int N_REQ = 2,
  parameter int SEL_W = 1,
  parameter int CNT_W = 16
);
  logic [N_REQ-1:0]    req;
  logic [16*N_REQ-1:0] req_nbytes;
  logic [N_REQ-1:0]    done;
  logic [N_REQ-1:0]    err;
  logic                send;
  logic [15:0]         nbytes;
  logic [SEL_W-1:0]    buf_sel;
  logic                tx_ready;
  logic                busy;
  logic [CNT_W-1:0]    frame_cnt;

  modport master (
    output req, req_nbytes, tx_ready,
    input  done, err, send, nbytes, buf_sel, busy, frame_cnt
  );

  modport slave (
    input  req, req_nbytes, tx_ready,
    output done, err, send, nbytes, buf_sel, busy, frame_cnt
  );
endinterface

// File: rtl/iob_eth_tx_sched.sv
// Round-robin frame scheduler in front of the Ethernet nibble transmitter (TX_CLK domain).
module iob_eth_tx_sched #(
  parameter int N_REQ    = 2,
  parameter int SEL_W    = 1,
  parameter int IFG_CYC  = 24,
  parameter int START_TO = 8,
  parameter int CNT_W    = 16
) (
  input logic              TX_CLK,
  input logic              tx_rst,
  iob_eth_tx_sched_if.slave bus
);

  typedef enum logic [2:0] {IDLE, SEND, WAIT_START, WAIT_END, GAP} state_t;

  localparam int TMAX  = (START_TO > IFG_CYC) ? START_TO : IFG_CYC;
  localparam int TMR_W = $clog2(TMAX + 1);
  localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

  state_t           state, state_nx;
  logic [TMR_W-1:0] timer, timer_nx;
  logic [SEL_W-1:0] rr_ptr, rr_nx;
  logic [SEL_W-1:0] sel_q, sel_nx;
  logic [15:0]      nb_q, nb_nx;
  logic [N_REQ-1:0] done_q, done_nx;
  logic [N_REQ-1:0] err_q, err_nx;
  logic [CNT_W-1:0] cnt_q, cnt_nx;

  logic [N_REQ-1:0] elig;
  logic             found;
  logic [SEL_W-1:0] win;
  logic [15:0]      nb_win;

  // A requester whose err pulse is still visible is excluded so it cannot be rejected twice.
  always_comb begin : arb
    logic [N_REQ-1:0] sh;
    int unsigned idx;
    elig   = bus.req & ~err_q;
    found  = 1'b0;
    win    = '0;
    nb_win = '0;
    sh     = '0;
    idx    = 0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      sh = elig >> idx;
      if (!found && sh[0]) begin
        found  = 1'b1;
        win    = SEL_W'(idx);
        nb_win = 16'(bus.req_nbytes >> (16 * idx));
      end
    end
  end

  always_comb begin : fsm
    state_nx = state;
    timer_nx = timer;
    rr_nx    = rr_ptr;
    sel_nx   = sel_q;
    nb_nx    = nb_q;
    done_nx  = '0;
    err_nx   = '0;
    cnt_nx   = cnt_q;
    unique case (state)
      IDLE: begin
        if (found) begin
          rr_nx  = win;
          sel_nx = win;
          nb_nx  = nb_win;
          if (nb_win == '0) err_nx = ONE << win;
          else              state_nx = SEND;
        end
      end
      SEND: begin
        timer_nx = '0;
        state_nx = WAIT_START;
      end
      WAIT_START: begin
        if (!bus.tx_ready) begin
          state_nx = WAIT_END;
        end else if (timer == TMR_W'(START_TO - 1)) begin
          err_nx   = ONE << sel_q;
          timer_nx = '0;
          state_nx = GAP;
        end else begin
          timer_nx = timer + 1'b1;
        end
      end
      WAIT_END: begin
        if (bus.tx_ready) begin
          done_nx  = ONE << sel_q;
          cnt_nx   = cnt_q + 1'b1;
          timer_nx = '0;
          state_nx = GAP;
        end
      end
      GAP: begin
        if (timer == TMR_W'(IFG_CYC - 1)) begin
          timer_nx = '0;
          state_nx = IDLE;
        end else begin
          timer_nx = timer + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge TX_CLK or posedge tx_rst) begin
    if (tx_rst) begin
      state  <= IDLE;
      timer  <= '0;
      rr_ptr <= SEL_W'(N_REQ - 1);
      sel_q  <= '0;
      nb_q   <= '0;
      done_q <= '0;
      err_q  <= '0;
      cnt_q  <= '0;
    end else begin
      state  <= state_nx;
      timer  <= timer_nx;
      rr_ptr <= rr_nx;
      sel_q  <= sel_nx;
      nb_q   <= nb_nx;
      done_q <= done_nx;
      err_q  <= err_nx;
      cnt_q  <= cnt_nx;
    end
  end

  assign bus.send      = (state == SEND);
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.nbytes    = nb_q;
  assign bus.buf_sel   = sel_q;
  assign bus.frame_cnt = cnt_q;

endmodule
